// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: valid/ready pipeline stage carrying payload plus PC, exception vector and delay-slot flag.
// Define PIPE_SKID_EN for a registered-ready two-entry skid stage; otherwise single entry with combinational ready.
module id_exe_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [31:0]       in_pc_i,
  input  logic [EXC_W-1:0]  in_exc_i,
  input  logic              in_ds_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [31:0]       out_pc_o,
  output logic [EXC_W-1:0]  out_exc_o,
  output logic              out_ds_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam int PW = DATA_W + 32 + EXC_W + 1;
  logic          r_valid;
  logic [PW-1:0] r_main;
  logic [CNT_W-1:0] r_cnt;
  logic          w_accept;
  logic [PW-1:0] w_in;
  assign w_in = {in_data_i, in_pc_i, in_exc_i, in_ds_i};
  assign w_accept = in_valid_i && in_ready_o;
  assign {out_data_o, out_pc_o, out_exc_o, out_ds_o} = r_main;
  assign out_valid_o = r_valid;
  assign stall_cnt_o = r_cnt;
`ifdef PIPE_SKID_EN
  logic          r_skid_valid;
  logic [PW-1:0] r_skid;
  // Ready depends only on skid occupancy, so no path from out_ready_i.
  assign in_ready_o = !r_skid_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_valid      <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else if (!r_valid || out_ready_i) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= w_accept;
        if (w_accept) r_main <= w_in;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_in;
    end
  end
`else
  assign in_ready_o = !r_valid || out_ready_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_main  <= w_in;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (r_valid && !out_ready_i && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb_id_exe_pipe_reg: scoreboard bench for id_exe_pipe_reg (CNT_W = 4 to reach saturation quickly).
module tb_id_exe_pipe_reg;
  typedef struct packed {
    logic [63:0] d;
    logic [31:0] pc;
    logic [31:0] exc;
    logic        ds;
  } ent_t;
  logic        clk = 0, rst = 0, flush_i = 0, in_valid_i = 0, in_ds_i = 0, out_ready_i = 0;
  logic        in_ready_o, out_valid_o, out_ds_o;
  logic [63:0] in_data_i = 0, out_data_o;
  logic [31:0] in_pc_i = 0, out_pc_o, in_exc_i = 0, out_exc_o;
  logic [3:0]  stall_cnt_o;
  int checks = 0, errors = 0;
  ent_t q[$];
  ent_t exp_e, obs, snap;
  id_exe_pipe_reg #(.DATA_W(64), .EXC_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_pc_i(in_pc_i), .in_exc_i(in_exc_i), .in_ds_i(in_ds_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_pc_o(out_pc_o), .out_exc_o(out_exc_o), .out_ds_o(out_ds_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  always_comb obs = '{out_data_o, out_pc_o, out_exc_o, out_ds_o};
  task automatic drive(input logic v, input logic [63:0] d, input logic [31:0] pc,
                       input logic [31:0] exc, input logic ds, input logic rdy);
    in_valid_i = v; in_data_i = d; in_pc_i = pc; in_exc_i = exc; in_ds_i = ds; out_ready_i = rdy;
  endtask
  task automatic do_reset();
    rst = 0; flush_i = 0;
    drive(0, 0, 0, 0, 0, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
  endtask
  task automatic test_reset();
    rst = 0;
    drive(1, 64'hdead, 32'h1234, 0, 1, 0);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || obs !== '0 || in_ready_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset: valid=%b fields=%h ready=%b cnt=%0d expected 0/0/1/0", out_valid_o, obs, in_ready_o, stall_cnt_o);
    end
    do_reset();
  endtask
  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 64'h1 + i, 32'hBFC00000 + 4 * i, 0, 0, 1);
      else drive(0, 0, 0, 0, 0, 1);
      #1;
      checks++;
      if (out_valid_o !== (i > 0)) begin
        errors++;
        $display("FAIL stream_valid[%0d]: got %b expected %b", i, out_valid_o, i > 0);
      end
      checks++;
      if (in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready_o);
      end
      if (out_valid_o && out_ready_i) begin
        exp_e = q.pop_front();
        checks++;
        if (obs !== exp_e) begin
          errors++;
          $display("FAIL stream_data[%0d]: got %h expected %h", i, obs, exp_e);
        end
      end
      if (in_valid_i && in_ready_o) q.push_back('{in_data_i, in_pc_i, in_exc_i, in_ds_i});
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: %0d entries left expected 0", q.size());
    end
  endtask
  task automatic test_stall();
    logic exp_rdy;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 64'h100 + k, 32'h8000_0000 + 4 * k, k, k[0], k == 0);
      #1;
`ifdef PIPE_SKID_EN
      exp_rdy = (k <= 1);
`else
      exp_rdy = (k == 0);
`endif
      checks++;
      if (in_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b expected %b", k, in_ready_o, exp_rdy);
      end
      if (k == 1) snap = obs;
      if (k > 1) begin
        checks++;
        if (obs !== snap || out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got %h/%b expected %h/1", k, obs, out_valid_o, snap);
        end
      end
      if (in_valid_i && in_ready_o) q.push_back('{in_data_i, in_pc_i, in_exc_i, in_ds_i});
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (stall_cnt_o !== 4'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 5", stall_cnt_o);
    end
    checks++;
`ifdef PIPE_SKID_EN
    if (q.size() != 2) begin
`else
    if (q.size() != 1) begin
`endif
      errors++;
      $display("FAIL stall_held: %0d entries accepted", q.size());
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      #1;
      if (out_valid_o && out_ready_i) begin
        exp_e = q.pop_front();
        checks++;
        if (obs !== exp_e) begin
          errors++;
          $display("FAIL stall_drain[%0d]: got %h expected %h", c, obs, exp_e);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (q.size() != 0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_lost: %0d undelivered, valid=%b expected 0/0", q.size(), out_valid_o);
    end
  endtask
  task automatic test_exc();
    do_reset();
    drive(1, 64'h77, 32'hBFC00180, 32'h00000010, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    out_ready_i = 1;
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_exc_o !== 32'h10 || out_ds_o !== 1'b1 || out_pc_o !== 32'hBFC00180) begin
      errors++;
      $display("FAIL exc_hold: valid=%b exc=%h ds=%b pc=%h expected 1/10/1/bfc00180", out_valid_o, out_exc_o, out_ds_o, out_pc_o);
    end
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_consume: valid=%b expected 0", out_valid_o);
    end
  endtask
  task automatic test_flush();
    do_reset();
    drive(1, 64'hA, 32'hA0, 1, 0, 0);
    @(negedge clk);
    drive(1, 64'hB, 32'hB0, 2, 1, 0);
    @(negedge clk);
    drive(1, 64'hC, 32'hC0, 3, 1, 1);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    drive(0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL flush: valid=%b ready=%b fields=%h expected 0/1/0", out_valid_o, in_ready_o, obs);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_drop[%0d]: valid=%b pc=%h expected valid 0", c, out_valid_o, out_pc_o);
      end
    end
  endtask
  task automatic test_saturate();
    do_reset();
    drive(1, 64'h55, 32'h1000, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    checks++;
    if (stall_cnt_o !== 4'hF) begin
      errors++;
      $display("FAIL saturate: got %h expected f", stall_cnt_o);
    end
    rst = 0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || obs !== '0 || in_ready_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b fields=%h ready=%b cnt=%0d expected 0/0/1/0", out_valid_o, obs, in_ready_o, stall_cnt_o);
    end
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_exc();
    test_flush();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
